// File: rtl/ham_pkg.sv
// Shared state encoding and ALU opcodes for the Hamming SECDED encode sequencer.
package ham_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_P4,
    S_P8,
    S_PKL,
    S_PKM,
    S_P0,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_P0  = 4'b1000;
  localparam logic [3:0] OP_P1  = 4'b1001;
  localparam logic [3:0] OP_P2  = 4'b1010;
  localparam logic [3:0] OP_P4  = 4'b1011;
  localparam logic [3:0] OP_P8  = 4'b1100;
  localparam logic [3:0] OP_PKL = 4'b1101;
  localparam logic [3:0] OP_PKM = 4'b1110;

endpackage

// File: rtl/ham_enc_seq.sv
// Hamming encode sequencer: steps the ALU through parity/packing opcodes and ORs results into LSW/MSW.
// Define HAM_P0_EN to add the overall-parity step (SECDED); otherwise SEC only with out_lsw[0] = 0.
module ham_enc_seq
  import ham_pkg::*;
#(
  parameter int W    = 8,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [10:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_lsw,
  output logic [W-1:0]    out_msw,
  output logic [OP_W-1:0] alu_op,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  input  logic [W-1:0]    alu_rslt,
  output logic            busy
);

  state_t          state_q, state_d;
  logic [10:0]     msg_q, msg_d;
  logic [W-1:0]    lsw_q, lsw_d;
  logic [W-1:0]    msw_q, msw_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      msg_q   <= '0;
      lsw_q   <= '0;
      msw_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      lsw_q   <= lsw_d;
      msw_q   <= msw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    lsw_d   = lsw_q;
    msw_d   = msw_q;
    alu_op  = OP_W'(OP_NOP);
    alu_a   = '0;
    alu_b   = '0;

    // Parity and packing steps all see the raw message as operands.
    if (state_q inside {S_P1, S_P2, S_P4, S_P8, S_PKL, S_PKM}) begin
      alu_a = msg_q[W-1:0];
      alu_b = W'(msg_q[10:8]);
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          msg_d   = in_data;
          lsw_d   = '0;
          msw_d   = '0;
          state_d = S_P1;
        end
      end
      S_P1: begin
        alu_op  = OP_W'(OP_P1);
        lsw_d   = lsw_q | alu_rslt;
        state_d = S_P2;
      end
      S_P2: begin
        alu_op  = OP_W'(OP_P2);
        lsw_d   = lsw_q | alu_rslt;
        state_d = S_P4;
      end
      S_P4: begin
        alu_op  = OP_W'(OP_P4);
        lsw_d   = lsw_q | alu_rslt;
        state_d = S_P8;
      end
      S_P8: begin
        alu_op  = OP_W'(OP_P8);
        msw_d   = msw_q | alu_rslt;
        state_d = S_PKL;
      end
      S_PKL: begin
        alu_op  = OP_W'(OP_PKL);
        lsw_d   = lsw_q | alu_rslt;
        state_d = S_PKM;
      end
      S_PKM: begin
        alu_op  = OP_W'(OP_PKM);
        msw_d   = msw_q | alu_rslt;
`ifdef HAM_P0_EN
        state_d = S_P0;
`else
        state_d = S_DONE;
`endif
      end
`ifdef HAM_P0_EN
      S_P0: begin
        // Overall parity spans the whole assembled codeword, so operands are the accumulators.
        alu_op   = OP_W'(OP_P0);
        alu_a    = lsw_q;
        alu_b    = msw_q;
        lsw_d[0] = lsw_q[0] | alu_rslt[0];
        state_d  = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_lsw   = lsw_q;
  assign out_msw   = msw_q;

endmodule
